// File: rtl/id_ex_reg_pkg.sv
// Shared pipeline constants: ALU op encodings, operand-select and control field widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package id_ex_reg_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int ALU_OP_W   = 4;
    localparam int ALU_SRC_W  = 1;
    localparam int MEM_CTRL_W = 1;

    // Operand-B select: immediate path vs register rt path.
    localparam logic [ALU_SRC_W-1:0] ALU_SRC_REG = 1'b0;
    localparam logic [ALU_SRC_W-1:0] ALU_SRC_IMM = 1'b1;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD  = 4'h0,
        ALU_SUB  = 4'h1,
        ALU_AND  = 4'h2,
        ALU_OR   = 4'h3,
        ALU_XOR  = 4'h4,
        ALU_NOR  = 4'h5,
        ALU_SLT  = 4'h6,
        ALU_SLTU = 4'h7,
        ALU_SLL  = 4'h8,
        ALU_SRL  = 4'h9,
        ALU_SRA  = 4'hA,
        ALU_LUI  = 4'hB
    } alu_op_e;

    // Execute-stage control bits that must never fire for a bubble or killed slot.
    typedef struct packed {
        logic [MEM_CTRL_W-1:0] mem_read;
        logic [MEM_CTRL_W-1:0] mem_write;
        logic                  reg_write;
        logic                  mem_to_reg;
    } ex_ctrl_t;

    // True when an instruction that reads 'addr' collides with a pending load target.
    function automatic logic src_hits(input logic uses, input logic [REG_ADDR_W-1:0] addr,
                                      input logic [REG_ADDR_W-1:0] load_dst);
        return uses && (addr == load_dst);
    endfunction

endpackage

// File: rtl/id_ex_reg_if.sv
// Decode-to-execute bundle: decode fields, redirect/stall controls, execute-stage copies.
// Latency: n/a (wiring only).
// Backpressure: stall_id flows back toward decode; ex_stall arrives from execute.
// Ports: master = decode/control side, slave = the ID/EX register.
interface id_ex_reg_if
    import id_ex_reg_pkg::*;
#(
    parameter int CNT_W = 16
) ();

    logic                  id_valid;
    logic [XLEN-1:0]       id_pc;
    logic [XLEN-1:0]       id_rs_data;
    logic [XLEN-1:0]       id_rt_data;
    logic [XLEN-1:0]       id_imm_ext;
    logic [REG_ADDR_W-1:0] id_rs_addr;
    logic [REG_ADDR_W-1:0] id_rt_addr;
    logic [REG_ADDR_W-1:0] id_rd_addr;
    logic                  id_uses_rs;
    logic                  id_uses_rt;
    logic [ALU_OP_W-1:0]   id_alu_op;
    logic [ALU_SRC_W-1:0]  id_alu_src;
    logic [MEM_CTRL_W-1:0] id_mem_read;
    logic [MEM_CTRL_W-1:0] id_mem_write;
    logic                  id_reg_write;
    logic                  id_mem_to_reg;
    logic                  flush;
    logic                  ex_stall;

    logic                  stall_id;
    logic                  ex_valid;
    logic [XLEN-1:0]       ex_pc;
    logic [XLEN-1:0]       ex_rs_data;
    logic [XLEN-1:0]       ex_op_b;
    logic [XLEN-1:0]       ex_rt_data;
    logic [REG_ADDR_W-1:0] ex_rt_addr;
    logic [REG_ADDR_W-1:0] ex_dst_addr;
    logic [ALU_OP_W-1:0]   ex_alu_op;
    logic [MEM_CTRL_W-1:0] ex_mem_read;
    logic [MEM_CTRL_W-1:0] ex_mem_write;
    logic                  ex_reg_write;
    logic                  ex_mem_to_reg;
    logic [CNT_W-1:0]      bubble_cnt;

    modport master (
        output id_valid, id_pc, id_rs_data, id_rt_data, id_imm_ext,
               id_rs_addr, id_rt_addr, id_rd_addr, id_uses_rs, id_uses_rt,
               id_alu_op, id_alu_src, id_mem_read, id_mem_write, id_reg_write,
               id_mem_to_reg, flush, ex_stall,
        input  stall_id, ex_valid, ex_pc, ex_rs_data, ex_op_b, ex_rt_data,
               ex_rt_addr, ex_dst_addr, ex_alu_op, ex_mem_read, ex_mem_write,
               ex_reg_write, ex_mem_to_reg, bubble_cnt
    );

    modport slave (
        input  id_valid, id_pc, id_rs_data, id_rt_data, id_imm_ext,
               id_rs_addr, id_rt_addr, id_rd_addr, id_uses_rs, id_uses_rt,
               id_alu_op, id_alu_src, id_mem_read, id_mem_write, id_reg_write,
               id_mem_to_reg, flush, ex_stall,
        output stall_id, ex_valid, ex_pc, ex_rs_data, ex_op_b, ex_rt_data,
               ex_rt_addr, ex_dst_addr, ex_alu_op, ex_mem_read, ex_mem_write,
               ex_reg_write, ex_mem_to_reg, bubble_cnt
    );

endinterface

// File: rtl/id_ex_reg_hazard_detect.sv
// Load-use hazard detector: decode reads the register a load in execute has not yet produced.
// Latency: purely combinational.
// Backpressure: load_use_o feeds the stall/bubble decision in id_ex_reg.
// Ports: ex_* = instruction now in execute, id_* = instruction in decode, load_use_o = hazard.
module hazard_detect
    import id_ex_reg_pkg::*;
(
    input  logic                  ex_valid_i,
    input  logic [MEM_CTRL_W-1:0] ex_mem_read_i,
    input  logic [REG_ADDR_W-1:0] ex_rt_addr_i,
    input  logic                  id_valid_i,
    input  logic                  id_uses_rs_i,
    input  logic                  id_uses_rt_i,
    input  logic [REG_ADDR_W-1:0] id_rs_addr_i,
    input  logic [REG_ADDR_W-1:0] id_rt_addr_i,
    output logic                  load_use_o
);

    logic pending_load;
    logic reads_target;

    // $0 is hardwired, so a load targeting it never creates a dependency.
    assign pending_load = ex_valid_i && (|ex_mem_read_i) && (ex_rt_addr_i != '0);
    assign reads_target = src_hits(id_uses_rs_i, id_rs_addr_i, ex_rt_addr_i) ||
                          src_hits(id_uses_rt_i, id_rt_addr_i, ex_rt_addr_i);
    assign load_use_o   = pending_load && reads_target && id_valid_i;

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with operand-B / destination muxing and load-use bubble insertion.
// Latency: one cycle decode-to-execute; stall_id is combinational.
// Backpressure: ex_stall holds every ex field; load-use inserts one bubble and raises stall_id; flush overrides both.
// Ports: clk, rst_n (async active-low), bus = id_ex_reg_if.slave.
module id_ex_reg
    import id_ex_reg_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    id_ex_reg_if.slave    bus
);

    logic                  load_use;

    logic                  ex_valid_q,    ex_valid_d;
    logic [XLEN-1:0]       ex_pc_q,       ex_pc_d;
    logic [XLEN-1:0]       ex_rs_data_q,  ex_rs_data_d;
    logic [XLEN-1:0]       ex_op_b_q,     ex_op_b_d;
    logic [XLEN-1:0]       ex_rt_data_q,  ex_rt_data_d;
    logic [REG_ADDR_W-1:0] ex_rt_addr_q,  ex_rt_addr_d;
    logic [REG_ADDR_W-1:0] ex_dst_addr_q, ex_dst_addr_d;
    logic [ALU_OP_W-1:0]   ex_alu_op_q,   ex_alu_op_d;
    ex_ctrl_t              ex_ctrl_q,     ex_ctrl_d;
    logic [CNT_W-1:0]      bubble_cnt_q,  bubble_cnt_d;

    hazard_detect u_hazard (
        .ex_valid_i    (ex_valid_q),
        .ex_mem_read_i (ex_ctrl_q.mem_read),
        .ex_rt_addr_i  (ex_rt_addr_q),
        .id_valid_i    (bus.id_valid),
        .id_uses_rs_i  (bus.id_uses_rs),
        .id_uses_rt_i  (bus.id_uses_rt),
        .id_rs_addr_i  (bus.id_rs_addr),
        .id_rt_addr_i  (bus.id_rt_addr),
        .load_use_o    (load_use)
    );

    // A redirect kills decode anyway, so holding it would only delay the new path.
    assign bus.stall_id = (bus.ex_stall || load_use) && !bus.flush;

    always_comb begin
        ex_valid_d    = ex_valid_q;
        ex_pc_d       = ex_pc_q;
        ex_rs_data_d  = ex_rs_data_q;
        ex_op_b_d     = ex_op_b_q;
        ex_rt_data_d  = ex_rt_data_q;
        ex_rt_addr_d  = ex_rt_addr_q;
        ex_dst_addr_d = ex_dst_addr_q;
        ex_alu_op_d   = ex_alu_op_q;
        ex_ctrl_d     = ex_ctrl_q;
        bubble_cnt_d  = bubble_cnt_q;

        if (bus.flush) begin
            // Data fields are left as-is; only valid and side-effecting controls matter.
            ex_valid_d = 1'b0;
            ex_ctrl_d  = '0;
        end else if (bus.ex_stall) begin
            // Hold everything: execute still owns the current contents.
        end else if (load_use) begin
            ex_valid_d   = 1'b0;
            ex_ctrl_d    = '0;
            bubble_cnt_d = (&bubble_cnt_q) ? bubble_cnt_q : bubble_cnt_q + CNT_W'(1);
        end else begin
            ex_valid_d    = bus.id_valid;
            ex_pc_d       = bus.id_pc;
            ex_rs_data_d  = bus.id_rs_data;
            ex_op_b_d     = (bus.id_alu_src == ALU_SRC_IMM) ? bus.id_imm_ext : bus.id_rt_data;
            ex_rt_data_d  = bus.id_rt_data;
            ex_rt_addr_d  = bus.id_rt_addr;
            // I-type writes rt; R-type writes rd.
            ex_dst_addr_d = (bus.id_alu_src == ALU_SRC_IMM) ? bus.id_rt_addr : bus.id_rd_addr;
            ex_alu_op_d   = bus.id_alu_op;
            // An invalid decode slot must never reach memory or the register file.
            ex_ctrl_d.mem_read   = bus.id_valid ? bus.id_mem_read  : '0;
            ex_ctrl_d.mem_write  = bus.id_valid ? bus.id_mem_write : '0;
            ex_ctrl_d.reg_write  = bus.id_valid && bus.id_reg_write;
            ex_ctrl_d.mem_to_reg = bus.id_valid && bus.id_mem_to_reg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q    <= 1'b0;
            ex_pc_q       <= '0;
            ex_rs_data_q  <= '0;
            ex_op_b_q     <= '0;
            ex_rt_data_q  <= '0;
            ex_rt_addr_q  <= '0;
            ex_dst_addr_q <= '0;
            ex_alu_op_q   <= '0;
            ex_ctrl_q     <= '0;
            bubble_cnt_q  <= '0;
        end else begin
            ex_valid_q    <= ex_valid_d;
            ex_pc_q       <= ex_pc_d;
            ex_rs_data_q  <= ex_rs_data_d;
            ex_op_b_q     <= ex_op_b_d;
            ex_rt_data_q  <= ex_rt_data_d;
            ex_rt_addr_q  <= ex_rt_addr_d;
            ex_dst_addr_q <= ex_dst_addr_d;
            ex_alu_op_q   <= ex_alu_op_d;
            ex_ctrl_q     <= ex_ctrl_d;
            bubble_cnt_q  <= bubble_cnt_d;
        end
    end

    assign bus.ex_valid      = ex_valid_q;
    assign bus.ex_pc         = ex_pc_q;
    assign bus.ex_rs_data    = ex_rs_data_q;
    assign bus.ex_op_b       = ex_op_b_q;
    assign bus.ex_rt_data    = ex_rt_data_q;
    assign bus.ex_rt_addr    = ex_rt_addr_q;
    assign bus.ex_dst_addr   = ex_dst_addr_q;
    assign bus.ex_alu_op     = ex_alu_op_q;
    assign bus.ex_mem_read   = ex_ctrl_q.mem_read;
    assign bus.ex_mem_write  = ex_ctrl_q.mem_write;
    assign bus.ex_reg_write  = ex_ctrl_q.reg_write;
    assign bus.ex_mem_to_reg = ex_ctrl_q.mem_to_reg;
    assign bus.bubble_cnt    = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_reg.sv
// Self-checking bench for id_ex_reg: directed hazard/flush/reset scenarios, then random traffic.
// Counter width is reduced so saturation is reachable in a short run.
// Expected values come from a transaction-level model of the execute slot.
module tb_id_ex_reg;

    localparam int CW      = 8;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    id_ex_reg_if #(.CNT_W(CW)) bus ();

    id_ex_reg #(.CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // What the execute slot should hold; 'known' is cleared where data is don't-care.
    typedef struct {
        logic        v;
        logic [31:0] pc, rs, opb, rt;
        logic [4:0]  rta, dst;
        logic [3:0]  op;
        logic        mr, mw, rw, m2r;
        logic        known;
    } slot_t;

    slot_t m;
    int    cnt;
    int    n_assert = 0;
    int    n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m = '{v: 1'b0, pc: '0, rs: '0, opb: '0, rt: '0, rta: '0, dst: '0, op: '0,
              mr: 1'b0, mw: 1'b0, rw: 1'b0, m2r: 1'b0, known: 1'b1};
        cnt = 0;
    endtask

    // Decode must wait when it reads the register a valid load in execute is about to write.
    function automatic logic model_hazard();
        logic needs_load_result;
        needs_load_result = (bus.id_uses_rs && bus.id_rs_addr == m.rta) ||
                            (bus.id_uses_rt && bus.id_rt_addr == m.rta);
        return bus.id_valid && m.v && m.mr && (m.rta != 5'd0) && needs_load_result;
    endfunction

    task automatic check_slot(input string tag);
        chk({tag, ".valid"},  32'(bus.ex_valid),      32'(m.v));
        chk({tag, ".mr"},     32'(bus.ex_mem_read),   32'(m.mr));
        chk({tag, ".mw"},     32'(bus.ex_mem_write),  32'(m.mw));
        chk({tag, ".rw"},     32'(bus.ex_reg_write),  32'(m.rw));
        chk({tag, ".m2r"},    32'(bus.ex_mem_to_reg), 32'(m.m2r));
        chk({tag, ".bubble"}, 32'(bus.bubble_cnt),    32'(cnt));
        if (m.known) begin
            chk({tag, ".pc"},   bus.ex_pc,               m.pc);
            chk({tag, ".rs"},   bus.ex_rs_data,          m.rs);
            chk({tag, ".opb"},  bus.ex_op_b,             m.opb);
            chk({tag, ".rt"},   bus.ex_rt_data,          m.rt);
            chk({tag, ".rta"},  32'(bus.ex_rt_addr),     32'(m.rta));
            chk({tag, ".dst"},  32'(bus.ex_dst_addr),    32'(m.dst));
            chk({tag, ".op"},   32'(bus.ex_alu_op),      32'(m.op));
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ".valid"},  32'(bus.ex_valid),      32'd0);
        chk({tag, ".ctrl"},   32'({bus.ex_mem_read, bus.ex_mem_write, bus.ex_reg_write, bus.ex_mem_to_reg}), 32'd0);
        chk({tag, ".pc"},     bus.ex_pc,              32'd0);
        chk({tag, ".rs"},     bus.ex_rs_data,         32'd0);
        chk({tag, ".opb"},    bus.ex_op_b,            32'd0);
        chk({tag, ".rt"},     bus.ex_rt_data,         32'd0);
        chk({tag, ".addr"},   32'({bus.ex_rt_addr, bus.ex_dst_addr, bus.ex_alu_op}), 32'd0);
        chk({tag, ".bubble"}, 32'(bus.bubble_cnt),    32'd0);
    endtask

    // Inputs are already driven; check stall_id, advance model and DUT one edge, check the slot.
    task automatic step(input string tag);
        logic hz;
        #1;
        hz = model_hazard();
        chk({tag, ".stall_id"}, 32'(bus.stall_id), 32'((bus.ex_stall || hz) && !bus.flush));
        if (bus.flush) begin
            m.v = 1'b0; m.mr = 1'b0; m.mw = 1'b0; m.rw = 1'b0; m.m2r = 1'b0; m.known = 1'b0;
        end else if (bus.ex_stall) begin
            // slot unchanged
        end else if (hz) begin
            m.v = 1'b0; m.mr = 1'b0; m.mw = 1'b0; m.rw = 1'b0; m.m2r = 1'b0; m.known = 1'b0;
            if (cnt < CNT_MAX) cnt++;
        end else begin
            m.v     = bus.id_valid;
            m.pc    = bus.id_pc;
            m.rs    = bus.id_rs_data;
            m.opb   = bus.id_alu_src ? bus.id_imm_ext : bus.id_rt_data;
            m.rt    = bus.id_rt_data;
            m.rta   = bus.id_rt_addr;
            m.dst   = bus.id_alu_src ? bus.id_rt_addr : bus.id_rd_addr;
            m.op    = bus.id_alu_op;
            m.mr    = bus.id_valid && bus.id_mem_read;
            m.mw    = bus.id_valid && bus.id_mem_write;
            m.rw    = bus.id_valid && bus.id_reg_write;
            m.m2r   = bus.id_valid && bus.id_mem_to_reg;
            m.known = 1'b1;
        end
        @(posedge clk);
        #1;
        check_slot(tag);
    endtask

    task automatic idle();
        bus.id_valid = 1'b0; bus.id_pc = '0; bus.id_rs_data = '0; bus.id_rt_data = '0;
        bus.id_imm_ext = '0; bus.id_rs_addr = '0; bus.id_rt_addr = '0; bus.id_rd_addr = '0;
        bus.id_uses_rs = 1'b0; bus.id_uses_rt = 1'b0; bus.id_alu_op = '0; bus.id_alu_src = '0;
        bus.id_mem_read = '0; bus.id_mem_write = '0; bus.id_reg_write = 1'b0;
        bus.id_mem_to_reg = 1'b0; bus.flush = 1'b0; bus.ex_stall = 1'b0;
    endtask

    // lw $rt, imm($rs)
    task automatic drive_lw(input logic [31:0] pc, input logic [4:0] rs, input logic [4:0] rt);
        idle();
        bus.id_valid = 1'b1; bus.id_pc = pc; bus.id_rs_addr = rs; bus.id_rt_addr = rt;
        bus.id_uses_rs = 1'b1; bus.id_alu_src = 1'b1; bus.id_imm_ext = 32'h10;
        bus.id_rs_data = 32'h1000; bus.id_alu_op = 4'h0;
        bus.id_mem_read = 1'b1; bus.id_reg_write = 1'b1; bus.id_mem_to_reg = 1'b1;
    endtask

    // add $rd, $rs, $rt
    task automatic drive_add(input logic [31:0] pc, input logic [4:0] rs, input logic [4:0] rt,
                             input logic [4:0] rd);
        idle();
        bus.id_valid = 1'b1; bus.id_pc = pc; bus.id_rs_addr = rs; bus.id_rt_addr = rt;
        bus.id_rd_addr = rd; bus.id_uses_rs = 1'b1; bus.id_uses_rt = 1'b1;
        bus.id_rs_data = 32'h11; bus.id_rt_data = 32'h22; bus.id_alu_op = 4'h0;
        bus.id_reg_write = 1'b1;
    endtask

    task automatic drive_random();
        bus.id_valid      = ($urandom_range(0, 7) != 0);
        bus.id_pc         = $urandom;
        bus.id_rs_data    = $urandom;
        bus.id_rt_data    = $urandom;
        bus.id_imm_ext    = $urandom;
        bus.id_rs_addr    = 5'($urandom_range(0, 3));
        bus.id_rt_addr    = 5'($urandom_range(0, 3));
        bus.id_rd_addr    = 5'($urandom_range(0, 31));
        bus.id_uses_rs    = 1'($urandom);
        bus.id_uses_rt    = 1'($urandom);
        bus.id_alu_op     = 4'($urandom);
        bus.id_alu_src    = 1'($urandom);
        bus.id_mem_read   = ($urandom_range(0, 2) == 0);
        bus.id_mem_write  = 1'($urandom);
        bus.id_reg_write  = 1'($urandom);
        bus.id_mem_to_reg = 1'($urandom);
        bus.flush         = ($urandom_range(0, 9) == 0);
        bus.ex_stall      = ($urandom_range(0, 5) == 0);
    endtask

    initial begin
        idle();
        model_reset();

        // Reset state, with the clock running underneath.
        #3;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Immediate operand and I-type destination.
        idle();
        bus.id_valid = 1'b1; bus.id_pc = 32'h100; bus.id_alu_src = 1'b1;
        bus.id_imm_ext = 32'hFFFFFFFD; bus.id_rt_data = 32'h5;
        bus.id_rt_addr = 5'd9; bus.id_rd_addr = 5'd3; bus.id_reg_write = 1'b1;
        step("imm");
        chk("imm.opb_const", bus.ex_op_b, 32'hFFFFFFFD);
        chk("imm.dst_const", 32'(bus.ex_dst_addr), 32'd9);

        // Register operand and R-type destination.
        bus.id_alu_src = 1'b0;
        step("reg");
        chk("reg.opb_const", bus.ex_op_b, 32'h5);
        chk("reg.dst_const", 32'(bus.ex_dst_addr), 32'd3);

        // Invalid decode slot never carries control bits.
        bus.id_valid = 1'b0; bus.id_mem_write = 1'b1;
        step("invalid");

        // Load-use on $8: one bubble, then the dependent add is captured.
        drive_lw(32'h200, 5'd4, 5'd8);
        step("lw8");
        drive_add(32'h204, 5'd8, 5'd2, 5'd7);
        step("lu_bubble");
        chk("lu.valid_const", 32'(bus.ex_valid), 32'd0);
        chk("lu.rw_const", 32'(bus.ex_reg_write), 32'd0);
        chk("lu.cnt_const", 32'(bus.bubble_cnt), 32'd1);
        step("lu_capture");
        chk("lu.pc_const", bus.ex_pc, 32'h204);

        // Load into $0 never creates a hazard.
        drive_lw(32'h300, 5'd4, 5'd0);
        step("lw0");
        drive_add(32'h304, 5'd0, 5'd0, 5'd7);
        step("lw0_nostall");
        chk("lw0.cnt_const", 32'(bus.bubble_cnt), 32'd1);

        // ex_stall for three cycles with a flush in the second.
        drive_add(32'h400, 5'd1, 5'd2, 5'd3);
        step("pre_stall");
        drive_add(32'h404, 5'd5, 5'd6, 5'd7);
        bus.ex_stall = 1'b1;
        step("stall1");
        chk("stall1.pc_const", bus.ex_pc, 32'h400);
        bus.flush = 1'b1;
        step("stall2_flush");
        chk("flush.valid_const", 32'(bus.ex_valid), 32'd0);
        bus.flush = 1'b0;
        step("stall3");

        // Asynchronous reset in the middle of a stall.
        drive_add(32'h500, 5'd1, 5'd2, 5'd3);
        step("pre_rst");
        bus.ex_stall = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        drive_add(32'h600, 5'd9, 5'd10, 5'd11);
        step("post_rst");
        chk("post_rst.pc_const", bus.ex_pc, 32'h600);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            drive_random();
            step("rand");
        end

        // Back-to-back loads into $8 that read $8: a bubble every other cycle until saturation.
        drive_lw(32'h700, 5'd8, 5'd8);
        for (int i = 0; i < 2 * CNT_MAX + 20; i++) begin
            step("sat");
        end
        chk("sat.cnt_const", 32'(bus.bubble_cnt), 32'(CNT_MAX));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
